// File: rtl/pixel_unpacker.sv
// Word-to-pixel serializer: unpacks 32-bit words into four 8-bit pixels over valid/ready,
// tracking position within a frame and flagging the last pixel.
module pixel_unpacker #(
   parameter int PIXELS_PER_FRAME = 16384,
   parameter int CNT_W            = 14
) (
   input  logic        clk,
   input  logic        n_rst,
   input  logic        clear,
   input  logic [31:0] word_in,
   input  logic        word_valid,
   output logic        word_ready,
   output logic [7:0]  pix_out,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        pix_last,
   output logic        frame_done
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PIXELS_PER_FRAME - 1);

   typedef enum logic {IDLE, EMIT} state_t;

   state_t            state, state_nxt;
   logic [31:0]       held, held_nxt;
   logic [1:0]        idx, idx_nxt;
   logic [CNT_W-1:0]  pix_cnt, pix_cnt_nxt;
   logic              frame_done_nxt;
   logic              word_xfer, pix_xfer;

   always_comb begin
      pix_valid  = (state == EMIT);
      word_ready = (state == IDLE) || (idx == 2'd3 && pix_ready);
      pix_xfer   = pix_valid && pix_ready;
      word_xfer  = word_valid && word_ready;
      pix_last   = pix_valid && (pix_cnt == LAST_CNT);

      pix_out = '0;
      if (pix_valid) begin
         unique case (idx)
            2'd0: pix_out = held[31:24];
            2'd1: pix_out = held[23:16];
            2'd2: pix_out = held[15:8];
            2'd3: pix_out = held[7:0];
         endcase
      end
   end

   always_comb begin
      state_nxt      = state;
      held_nxt       = held;
      idx_nxt        = idx;
      pix_cnt_nxt    = pix_cnt;
      frame_done_nxt = pix_xfer && pix_last;

      unique case (state)
         IDLE: begin
            if (word_xfer) begin
               state_nxt = EMIT;
               held_nxt  = word_in;
               idx_nxt   = '0;
            end
         end
         EMIT: begin
            if (pix_xfer) begin
               if (idx == 2'd3) begin
                  idx_nxt = '0;
                  // A word can only transfer here on the final pixel, giving bubble-free chaining.
                  if (word_xfer) held_nxt = word_in;
                  else           state_nxt = IDLE;
               end else begin
                  idx_nxt = idx + 2'd1;
               end
            end
         end
      endcase

      if (pix_xfer) pix_cnt_nxt = (pix_cnt == LAST_CNT) ? '0 : pix_cnt + 1'b1;

      if (clear) begin
         state_nxt      = IDLE;
         held_nxt       = '0;
         idx_nxt        = '0;
         pix_cnt_nxt    = '0;
         frame_done_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= IDLE;
         held       <= '0;
         idx        <= '0;
         pix_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         held       <= held_nxt;
         idx        <= idx_nxt;
         pix_cnt    <= pix_cnt_nxt;
         frame_done <= frame_done_nxt;
      end
   end

endmodule
